// File: rtl/mine_pkg.sv
// Shared types and helpers for the mine field generator.
package mine_pkg;

  // Placement sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_CHECK,
    S_SCAN,
    S_DONE
  } state_t;

  // Bits needed to address n items; never less than one bit.
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Flat cell index: row-major, row 0 / column 0 at bit 0.
  function automatic int unsigned cell_index(input int unsigned r, input int unsigned c,
                                             input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/mine_cell_check.sv
// Combinational accept test for one candidate cell: on the grid, not yet
// mined, and outside the player's safe zone.
module mine_cell_check #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int RW         = 3,
  parameter int CW         = 3,
  parameter int SAFE_NEIGH = 1
) (
  input  logic [RW-1:0] cand_row,
  input  logic [CW-1:0] cand_col,
  input  logic          safe_valid,
  input  logic [RW-1:0] safe_row,
  input  logic [CW-1:0] safe_col,
  input  logic          occupied,
  output logic          in_range,
  output logic          accept
);

  logic [RW-1:0] row_diff;
  logic [CW-1:0] col_diff;
  logic          near_safe;

  // Unsigned distance without wrap, so row 0 never neighbours the last row.
  assign row_diff = (cand_row >= safe_row) ? (cand_row - safe_row) : (safe_row - cand_row);
  assign col_diff = (cand_col >= safe_col) ? (cand_col - safe_col) : (safe_col - cand_col);

  generate
    if (SAFE_NEIGH != 0) begin : g_neigh
      assign near_safe = (row_diff <= RW'(1)) && (col_diff <= CW'(1));
    end else begin : g_exact
      assign near_safe = (cand_row == safe_row) && (cand_col == safe_col);
    end
  endgenerate

  assign in_range = (int'(cand_row) < ROWS) && (int'(cand_col) < COLS);
  assign accept   = in_range && !occupied && !(safe_valid && near_safe);

endmodule

// File: rtl/mine_field_gen.sv
// Places NUM_MINES distinct mines on a ROWS x COLS grid from a random
// source, with bounded retries followed by a linear scan fallback.
module mine_field_gen
  import mine_pkg::*;
#(
  parameter  int ROWS       = 8,
  parameter  int COLS       = 8,
  parameter  int NUM_MINES  = 10,
  parameter  int SAFE_NEIGH = 1,
  parameter  int MAX_TRIES  = 8,
  localparam int CELLS      = ROWS * COLS,
  localparam int RW         = bits_for(ROWS),
  localparam int CW         = bits_for(COLS),
  localparam int RAND_W     = RW + CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              safe_valid,
  input  logic [RW-1:0]     safe_row,
  input  logic [CW-1:0]     safe_col,
  input  logic [RAND_W-1:0] rand_val,
  output logic              busy,
  output logic              done,
  output logic [CELLS-1:0]  mine_map
);

  localparam int IW = bits_for(CELLS);
  localparam int PW = bits_for(NUM_MINES + 1);
  localparam int TW = bits_for(MAX_TRIES);

  generate
    if (NUM_MINES < 1 || NUM_MINES > CELLS - 9) begin : g_bad_cfg
      $error("mine_field_gen: NUM_MINES must be within 1 .. ROWS*COLS-9");
    end
  endgenerate

  state_t        state_reg;
  logic          start_q;
  logic [PW-1:0] placed_reg;
  logic [TW-1:0] tries_reg;
  logic [RW-1:0] cand_row_reg;
  logic [CW-1:0] cand_col_reg;
  logic          safe_valid_reg;
  logic [RW-1:0] safe_row_reg;
  logic [CW-1:0] safe_col_reg;

  logic          in_range;
  logic          accept;
  logic [IW-1:0] cand_idx;
  logic          last_mine;

  // Out-of-range candidates are steered to cell 0 so the map read stays in bounds;
  // the checker rejects them regardless.
  assign cand_idx  = in_range ? IW'(cell_index(32'(cand_row_reg), 32'(cand_col_reg), COLS)) : '0;
  assign last_mine = (placed_reg == PW'(NUM_MINES - 1));

  mine_cell_check #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .RW        (RW),
    .CW        (CW),
    .SAFE_NEIGH(SAFE_NEIGH)
  ) u_check (
    .cand_row  (cand_row_reg),
    .cand_col  (cand_col_reg),
    .safe_valid(safe_valid_reg),
    .safe_row  (safe_row_reg),
    .safe_col  (safe_col_reg),
    .occupied  (mine_map[cand_idx]),
    .in_range  (in_range),
    .accept    (accept)
  );

  // Placement sequencer; a start edge in any state restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      start_q        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mine_map       <= '0;
      placed_reg     <= '0;
      tries_reg      <= '0;
      cand_row_reg   <= '0;
      cand_col_reg   <= '0;
      safe_valid_reg <= 1'b0;
      safe_row_reg   <= '0;
      safe_col_reg   <= '0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      if (start && !start_q) begin
        state_reg <= S_CLEAR;
        busy      <= 1'b1;
      end else begin
        case (state_reg)
          S_IDLE: ;
          S_CLEAR: begin
            mine_map       <= '0;
            placed_reg     <= '0;
            tries_reg      <= '0;
            safe_valid_reg <= safe_valid;
            safe_row_reg   <= safe_row;
            safe_col_reg   <= safe_col;
            state_reg      <= S_DRAW;
          end
          S_DRAW: begin
            cand_row_reg <= rand_val[RAND_W-1:CW];
            cand_col_reg <= rand_val[CW-1:0];
            state_reg    <= S_CHECK;
          end
          S_CHECK, S_SCAN: begin
            if (accept) begin
              mine_map[cand_idx] <= 1'b1;
              placed_reg         <= placed_reg + PW'(1);
              tries_reg          <= '0;
              if (last_mine) begin
                state_reg <= S_DONE;
                done      <= 1'b1;
              end else begin
                state_reg <= S_DRAW;
              end
            end else if (state_reg == S_CHECK) begin
              tries_reg <= tries_reg + TW'(1);
              state_reg <= (tries_reg == TW'(MAX_TRIES - 1)) ? S_SCAN : S_DRAW;
            end else if (!in_range) begin
              cand_row_reg <= '0;
              cand_col_reg <= '0;
            end else if (cand_col_reg == CW'(COLS - 1)) begin
              cand_col_reg <= '0;
              cand_row_reg <= (cand_row_reg == RW'(ROWS - 1)) ? '0 : cand_row_reg + RW'(1);
            end else begin
              cand_col_reg <= cand_col_reg + CW'(1);
            end
          end
          S_DONE: begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule
